// File: rtl/priv_trap_ctrl.sv
// priv_trap_ctrl: machine-mode trap controller.
// Latches local interrupt pulses, arbitrates interrupts against synchronous
// exceptions, waits for the pipeline to drain, then commits the trap
// (mcause/mepc/mtval injection plus PC redirect). Also sequences mret.
module priv_trap_ctrl #(
    parameter int NUM_LOCAL_INT = 16,
    parameter int VECTORED_EN   = 1
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          timer_int_m,
    input  logic                          soft_int_m,
    input  logic                          ext_int_m,
    input  logic [NUM_LOCAL_INT-1:0]      local_int,
    input  logic [NUM_LOCAL_INT-1:0]      clear_local_int,
    input  logic                          mstatus_mie,
    input  logic [16+NUM_LOCAL_INT-1:0]   mie_mask,
    input  logic                          exc_valid,
    input  logic [4:0]                    exc_cause,
    input  logic [31:0]                   exc_tval,
    input  logic [31:0]                   epc,
    input  logic                          mret,
    input  logic                          pipe_clear,
    input  logic [31:0]                   mtvec,
    input  logic [31:0]                   mepc,
    output logic [16+NUM_LOCAL_INT-1:0]   pending,
    output logic                          inject,
    output logic [31:0]                   next_mcause,
    output logic [31:0]                   next_mepc,
    output logic [31:0]                   next_mtval,
    output logic                          intr,
    output logic                          insert_pc,
    output logic [31:0]                   priv_pc
);

    localparam int W = 16 + NUM_LOCAL_INT;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_CLEAR = 2'd1,
        S_COMMIT     = 2'd2,
        S_RET_WAIT   = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_LOCAL_INT-1:0]  local_pend_q, local_pend_d;
    logic [W-1:0]              pending_s, enabled_s;
    logic                      has_int_s, cap_in_e_s;
    logic [5:0]                win_local_s, win_code_s;
    logic                      capture_exc_s, capture_int_s;
    logic                      cap_int_q, cap_int_d;
    logic [5:0]                cap_code_q, cap_code_d;
    logic [31:0]               cap_epc_q, cap_epc_d;
    logic [31:0]               cap_tval_q, cap_tval_d;
    logic                      commit_s, ret_s, use_vec_s;
    logic [31:0]               trap_base_s;
    logic                      inject_q, inject_d;
    logic                      intr_q, intr_d;
    logic                      insert_pc_q, insert_pc_d;
    logic [31:0]               mcause_q, mcause_d;
    logic [31:0]               mepc_q, mepc_d;
    logic [31:0]               mtval_q, mtval_d;
    logic [31:0]               priv_pc_q, priv_pc_d;

    // Local pending update: clear pulses first, so a coincident set wins.
    always_comb begin
        local_pend_d = (local_pend_q & ~clear_local_int) | local_int;
    end

    // mip view: standard bits mirror live inputs, local bits come from the latch.
    always_comb begin
        pending_s              = '0;
        pending_s[3]           = soft_int_m;
        pending_s[7]           = timer_int_m;
        pending_s[11]          = ext_int_m;
        pending_s[W-1:16]      = local_pend_q;
    end

    assign enabled_s = pending_s & mie_mask & {W{mstatus_mie}};
    assign has_int_s = |enabled_s;
    assign pending   = pending_s;

    // Interrupt arbitration: 11 > 3 > 7 > highest-index local.
    always_comb begin
        win_local_s = 6'd0;
        for (int i = 0; i < NUM_LOCAL_INT; i++) begin
            win_local_s = enabled_s[16+i] ? 6'(16 + i) : win_local_s;
        end
        if (enabled_s[11]) begin
            win_code_s = 6'd11;
        end else if (enabled_s[3]) begin
            win_code_s = 6'd3;
        end else if (enabled_s[7]) begin
            win_code_s = 6'd7;
        end else begin
            win_code_s = win_local_s;
        end
    end

    // Is the captured interrupt cause still enabled and pending?
    always_comb begin
        cap_in_e_s = 1'b0;
        for (int i = 0; i < W; i++) begin
            cap_in_e_s = cap_in_e_s | (enabled_s[i] & (cap_code_q == 6'(i)));
        end
    end

    // An exception is captured from IDLE/RET_WAIT, or preempts a captured interrupt.
    assign capture_exc_s = exc_valid &&
                           ((state_q == S_IDLE) || (state_q == S_RET_WAIT) ||
                            ((state_q == S_WAIT_CLEAR) && cap_int_q));
    assign capture_int_s = (state_q == S_IDLE) && !exc_valid && has_int_s;

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (exc_valid || has_int_s) begin
                    state_d = S_WAIT_CLEAR;
                end else if (mret) begin
                    state_d = S_RET_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_CLEAR: begin
                if (exc_valid && cap_int_q) begin
                    state_d = S_WAIT_CLEAR;
                end else if (pipe_clear) begin
                    // A withdrawn interrupt is dropped rather than committed.
                    state_d = (cap_int_q && !cap_in_e_s) ? S_IDLE : S_COMMIT;
                end else begin
                    state_d = S_WAIT_CLEAR;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            S_RET_WAIT: begin
                if (exc_valid) begin
                    state_d = S_WAIT_CLEAR;
                end else if (pipe_clear) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RET_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values of the captured trap record.
    always_comb begin
        cap_int_d  = cap_int_q;
        cap_code_d = cap_code_q;
        cap_epc_d  = cap_epc_q;
        cap_tval_d = cap_tval_q;
        if (capture_exc_s) begin
            cap_int_d  = 1'b0;
            cap_code_d = {1'b0, exc_cause};
            cap_epc_d  = epc;
            cap_tval_d = exc_tval;
        end else if (capture_int_s) begin
            cap_int_d  = 1'b1;
            cap_code_d = win_code_s;
            cap_epc_d  = epc;
            cap_tval_d = 32'd0;
        end else begin
            cap_int_d  = cap_int_q;
        end
    end

    // Registered outputs are loaded on the edge entering the commit/redirect cycle.
    assign commit_s    = (state_q == S_WAIT_CLEAR) && (state_d == S_COMMIT);
    assign ret_s       = (state_q == S_RET_WAIT) && !exc_valid && pipe_clear;
    assign use_vec_s   = (VECTORED_EN != 0) && cap_int_q && (mtvec[1:0] == 2'b01);
    assign trap_base_s = {mtvec[31:2], 2'b00};

    // FSM output logic (next values of the registered outputs).
    always_comb begin
        inject_d    = 1'b0;
        intr_d      = 1'b0;
        insert_pc_d = 1'b0;
        mcause_d    = 32'd0;
        mepc_d      = 32'd0;
        mtval_d     = 32'd0;
        priv_pc_d   = 32'd0;
        if (commit_s) begin
            inject_d    = 1'b1;
            intr_d      = 1'b1;
            insert_pc_d = 1'b1;
            mcause_d    = {cap_int_q, 25'd0, cap_code_q};
            mepc_d      = cap_epc_q;
            mtval_d     = cap_tval_q;
            priv_pc_d   = use_vec_s ? (trap_base_s + {24'd0, cap_code_q, 2'b00})
                                    : trap_base_s;
        end else if (ret_s) begin
            insert_pc_d = 1'b1;
            priv_pc_d   = mepc;
        end else begin
            inject_d    = 1'b0;
        end
    end

    // Pending latch, trap record and registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            local_pend_q <= '0;
            cap_int_q    <= 1'b0;
            cap_code_q   <= 6'd0;
            cap_epc_q    <= 32'd0;
            cap_tval_q   <= 32'd0;
            inject_q     <= 1'b0;
            intr_q       <= 1'b0;
            insert_pc_q  <= 1'b0;
            mcause_q     <= 32'd0;
            mepc_q       <= 32'd0;
            mtval_q      <= 32'd0;
            priv_pc_q    <= 32'd0;
        end else begin
            local_pend_q <= local_pend_d;
            cap_int_q    <= cap_int_d;
            cap_code_q   <= cap_code_d;
            cap_epc_q    <= cap_epc_d;
            cap_tval_q   <= cap_tval_d;
            inject_q     <= inject_d;
            intr_q       <= intr_d;
            insert_pc_q  <= insert_pc_d;
            mcause_q     <= mcause_d;
            mepc_q       <= mepc_d;
            mtval_q      <= mtval_d;
            priv_pc_q    <= priv_pc_d;
        end
    end

    assign inject      = inject_q;
    assign intr        = intr_q;
    assign insert_pc   = insert_pc_q;
    assign next_mcause = mcause_q;
    assign next_mepc   = mepc_q;
    assign next_mtval  = mtval_q;
    assign priv_pc     = priv_pc_q;

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// tb_priv_trap_ctrl: directed test-plan scenarios followed by randomized
// traffic, all checked every cycle against a behavioural trap model.
module tb_priv_trap_ctrl;

    localparam int NL = 16;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          timer_int_m, soft_int_m, ext_int_m;
    logic [NL-1:0] local_int, clear_local_int;
    logic          mstatus_mie;
    logic [31:0]   mie_mask;
    logic          exc_valid;
    logic [4:0]    exc_cause;
    logic [31:0]   exc_tval, epc;
    logic          mret, pipe_clear;
    logic [31:0]   mtvec, mepc;
    logic [31:0]   pending;
    logic          inject, intr, insert_pc;
    logic [31:0]   next_mcause, next_mepc, next_mtval, priv_pc;

    int n_cmp = 0;
    int n_mis = 0;

    priv_trap_ctrl #(.NUM_LOCAL_INT(NL), .VECTORED_EN(1)) dut (
        .CLK(CLK), .nRST(nRST),
        .timer_int_m(timer_int_m), .soft_int_m(soft_int_m), .ext_int_m(ext_int_m),
        .local_int(local_int), .clear_local_int(clear_local_int),
        .mstatus_mie(mstatus_mie), .mie_mask(mie_mask),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .epc(epc),
        .mret(mret), .pipe_clear(pipe_clear), .mtvec(mtvec), .mepc(mepc),
        .pending(pending), .inject(inject),
        .next_mcause(next_mcause), .next_mepc(next_mepc), .next_mtval(next_mtval),
        .intr(intr), .insert_pc(insert_pc), .priv_pc(priv_pc)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase of the trap sequence: 0 idle, 1 waiting for drain, 2 commit cycle, 3 mret wait.
    int          m_phase;
    logic [NL-1:0] m_lp;
    logic        m_is_int;
    int          m_code;
    logic [31:0] m_epc, m_tval;
    logic        x_inject, x_intr, x_ins;
    logic [31:0] x_mcause, x_mepc, x_mtval, x_pc;

    function automatic logic [31:0] model_enabled(input logic [NL-1:0] lp);
        logic [31:0] e;
        e = 32'd0;
        if (mstatus_mie) begin
            e[3]  = soft_int_m  & mie_mask[3];
            e[7]  = timer_int_m & mie_mask[7];
            e[11] = ext_int_m   & mie_mask[11];
            for (int i = 0; i < NL; i++) e[16+i] = lp[i] & mie_mask[16+i];
        end
        return e;
    endfunction

    function automatic int model_winner(input logic [31:0] e);
        if (e[11]) return 11;
        if (e[3])  return 3;
        if (e[7])  return 7;
        for (int i = NL - 1; i >= 0; i--) if (e[16+i]) return 16 + i;
        return -1;
    endfunction

    function automatic logic [31:0] model_target(input logic is_int, input int code);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (is_int && mtvec[1:0] == 2'b01) return base + 32'(4 * code);
        return base;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_phase <= 0; m_lp <= '0; m_is_int <= 1'b0; m_code <= 0;
            m_epc <= 32'd0; m_tval <= 32'd0;
            x_inject <= 1'b0; x_intr <= 1'b0; x_ins <= 1'b0;
            x_mcause <= 32'd0; x_mepc <= 32'd0; x_mtval <= 32'd0; x_pc <= 32'd0;
        end else begin
            x_inject <= 1'b0; x_intr <= 1'b0; x_ins <= 1'b0;
            x_mcause <= 32'd0; x_mepc <= 32'd0; x_mtval <= 32'd0; x_pc <= 32'd0;
            m_lp <= (m_lp & ~clear_local_int) | local_int;
            if (m_phase == 0) begin
                if (exc_valid) begin
                    m_is_int <= 1'b0; m_code <= int'(exc_cause); m_epc <= epc; m_tval <= exc_tval;
                    m_phase <= 1;
                end else if (model_winner(model_enabled(m_lp)) >= 0) begin
                    m_is_int <= 1'b1; m_code <= model_winner(model_enabled(m_lp));
                    m_epc <= epc; m_tval <= 32'd0;
                    m_phase <= 1;
                end else if (mret) begin
                    m_phase <= 3;
                end
            end else if (m_phase == 1) begin
                if (exc_valid && m_is_int) begin
                    m_is_int <= 1'b0; m_code <= int'(exc_cause); m_epc <= epc; m_tval <= exc_tval;
                end else if (pipe_clear) begin
                    if (m_is_int && !model_enabled(m_lp)[m_code]) begin
                        m_phase <= 0;
                    end else begin
                        x_inject <= 1'b1; x_intr <= 1'b1; x_ins <= 1'b1;
                        x_mcause <= {m_is_int, 31'(m_code)};
                        x_mepc <= m_epc; x_mtval <= m_tval;
                        x_pc <= model_target(m_is_int, m_code);
                        m_phase <= 2;
                    end
                end
            end else if (m_phase == 2) begin
                m_phase <= 0;
            end else begin
                if (exc_valid) begin
                    m_is_int <= 1'b0; m_code <= int'(exc_cause); m_epc <= epc; m_tval <= exc_tval;
                    m_phase <= 1;
                end else if (pipe_clear) begin
                    x_ins <= 1'b1; x_pc <= mepc;
                    m_phase <= 0;
                end
            end
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        chk("pending", 64'(pending), 64'({m_lp, 4'b0, ext_int_m, 3'b0, timer_int_m, 3'b0, soft_int_m, 3'b0}));
        chk("inject", 64'(inject), 64'(x_inject));
        chk("intr", 64'(intr), 64'(x_intr));
        chk("insert_pc", 64'(insert_pc), 64'(x_ins));
        chk("next_mcause", 64'(next_mcause), 64'(x_mcause));
        chk("next_mepc", 64'(next_mepc), 64'(x_mepc));
        chk("next_mtval", 64'(next_mtval), 64'(x_mtval));
        chk("priv_pc", 64'(priv_pc), 64'(x_pc));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_intr(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (intr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic settle();
        mstatus_mie = 1'b0; exc_valid = 1'b0; mret = 1'b0; pipe_clear = 1'b1;
        timer_int_m = 1'b0; soft_int_m = 1'b0; ext_int_m = 1'b0; local_int = '0;
        clear_local_int = '1;
        tick();
        clear_local_int = '0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    bit ok;
    int cnt;
    logic [31:0] seen_pc;

    initial begin
        nRST = 1'b0;
        timer_int_m = 1'b0; soft_int_m = 1'b0; ext_int_m = 1'b0;
        local_int = '0; clear_local_int = '0; mstatus_mie = 1'b0; mie_mask = 32'd0;
        exc_valid = 1'b0; exc_cause = 5'd0; exc_tval = 32'd0; epc = 32'd0;
        mret = 1'b0; pipe_clear = 1'b0; mtvec = 32'd0; mepc = 32'd0;
        tick(); tick();
        chk("rst_intr", 64'(intr), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        nRST = 1'b1;
        tick();

        // Local interrupt 2, vectored.
        mstatus_mie = 1'b1; mie_mask = 32'h0004_0000; mtvec = 32'h8000_0001;
        pipe_clear = 1'b1; epc = 32'h0000_0040; local_int = 16'h0004;
        tick();
        local_int = '0;
        chk("t1_pend_vis", 64'(pending[18]), 64'd1);
        tick(); tick();
        chk("t1_intr", 64'(intr), 64'd1);
        chk("t1_inject", 64'(inject), 64'd1);
        chk("t1_mcause", 64'(next_mcause), 64'h8000_0012);
        chk("t1_pc", 64'(priv_pc), 64'h8000_0048);
        chk("t1_mepc", 64'(next_mepc), 64'h0000_0040);
        settle();

        // External beats local; then local after external drops.
        mstatus_mie = 1'b1; mie_mask = 32'h0020_0800; mtvec = 32'h8000_0000;
        pipe_clear = 1'b1; ext_int_m = 1'b1; local_int = 16'h0020;
        tick();
        local_int = '0;
        wait_intr(6, ok);
        chk("t2_seen_a", 64'(ok), 64'd1);
        chk("t2_mcause_a", 64'(next_mcause), 64'h8000_000B);
        chk("t2_pc_a", 64'(priv_pc), 64'h8000_0000);
        ext_int_m = 1'b0;
        wait_intr(6, ok);
        chk("t2_seen_b", 64'(ok), 64'd1);
        chk("t2_mcause_b", 64'(next_mcause), 64'h8000_0015);
        settle();

        // Exception preempts a captured interrupt.
        mstatus_mie = 1'b1; mie_mask = 32'h0000_0080; mtvec = 32'h8000_0001;
        pipe_clear = 1'b0; timer_int_m = 1'b1; epc = 32'h0000_0200;
        tick(); tick(); tick();
        exc_valid = 1'b1; exc_cause = 5'd2; exc_tval = 32'hDEAD_BEEF; epc = 32'h0000_0100;
        tick();
        exc_valid = 1'b0; timer_int_m = 1'b0; pipe_clear = 1'b1;
        wait_intr(4, ok);
        chk("t3_seen", 64'(ok), 64'd1);
        chk("t3_mcause", 64'(next_mcause), 64'h0000_0002);
        chk("t3_mtval", 64'(next_mtval), 64'hDEAD_BEEF);
        chk("t3_mepc", 64'(next_mepc), 64'h0000_0100);
        chk("t3_pc", 64'(priv_pc), 64'h8000_0000);
        settle();

        // Timer withdrawn before drain: no trap.
        mstatus_mie = 1'b1; mie_mask = 32'h0000_0080; pipe_clear = 1'b0; timer_int_m = 1'b1;
        tick();
        timer_int_m = 1'b0;
        tick();
        pipe_clear = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            cnt += int'(inject) + int'(insert_pc);
        end
        chk("t4_no_inject", 64'(cnt), 64'd0);
        settle();

        // mret with a delayed drain.
        pipe_clear = 1'b0; mret = 1'b1; mepc = 32'h0000_1234;
        tick();
        mret = 1'b0;
        tick(); tick();
        pipe_clear = 1'b1;
        cnt = 0; seen_pc = 32'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (insert_pc) begin
                cnt++;
                seen_pc = priv_pc;
            end
        end
        chk("t5_count", 64'(cnt), 64'd1);
        chk("t5_pc", 64'(seen_pc), 64'h0000_1234);
        settle();

        // Coincident set/clear, then reset in WAIT_CLEAR.
        local_int = 16'h0001; clear_local_int = 16'h0001;
        tick();
        local_int = '0; clear_local_int = '0;
        chk("t6_set_wins", 64'(pending[16]), 64'd1);
        mie_mask = 32'h0001_0000; mstatus_mie = 1'b1; pipe_clear = 1'b0;
        tick();
        nRST = 1'b0;
        #1;
        chk("t6_rst_pend", 64'(pending[16]), 64'd0);
        pipe_clear = 1'b1;
        tick();
        chk("t6_rst_inject", 64'(inject), 64'd0);
        nRST = 1'b1;
        tick(); tick();
        chk("t6_after_intr", 64'(intr), 64'd0);
        chk("t6_after_ins", 64'(insert_pc), 64'd0);
        settle();

        // Randomized traffic.
        mie_mask = $urandom;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) timer_int_m = ~timer_int_m;
            if ($urandom_range(0, 7) == 0) soft_int_m = ~soft_int_m;
            if ($urandom_range(0, 7) == 0) ext_int_m = ~ext_int_m;
            local_int = ($urandom_range(0, 5) == 0) ? NL'(1 << $urandom_range(0, NL - 1)) : '0;
            clear_local_int = ($urandom_range(0, 7) == 0) ? NL'($urandom) : '0;
            if ($urandom_range(0, 49) == 0) mie_mask = $urandom;
            mstatus_mie = ($urandom_range(0, 9) != 0);
            exc_valid = ($urandom_range(0, 11) == 0);
            exc_cause = 5'($urandom);
            exc_tval = $urandom;
            epc = $urandom;
            mret = ($urandom_range(0, 9) == 0);
            pipe_clear = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 29) == 0) mtvec = $urandom;
            mepc = $urandom;
            nRST = ($urandom_range(0, 399) != 0);
            tick();
        end
        nRST = 1'b1;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
